// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter driving one shared 32-bit ALU, with a held, id-tagged
// response channel. Define ALU_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
module alu_arbiter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_src1,
  input  logic [W-1:0] req0_src2,
  input  logic [3:0]   req0_ctrl,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_src1,
  input  logic [W-1:0] req1_src2,
  input  logic [3:0]   req1_ctrl,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_cout,
  output logic         rsp_overflow,
  output logic         rsp_err,
  output logic         busy
);

  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] CTRL_AND  = 4'b0000;
  localparam logic [CW-1:0] CTRL_OR   = 4'b0001;
  localparam logic [CW-1:0] CTRL_ADD  = 4'b0010;
  localparam logic [CW-1:0] CTRL_SUB  = 4'b0110;
  localparam logic [CW-1:0] CTRL_SLT  = 4'b0111;
  localparam logic [CW-1:0] CTRL_NOR  = 4'b1100;
  localparam logic [CW-1:0] CTRL_NAND = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]  op_src1_q, op_src2_q;
  logic [CW-1:0] op_ctrl_q;
  logic          op_id_q;

  logic [W-1:0]  rsp_result_q, rsp_result_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic          rsp_cout_q, rsp_cout_d;
  logic          rsp_ovf_q, rsp_ovf_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_id_q;

  logic          accept_c, grant_id_c, capture_c, prio0_c;
  logic          op_supported_c, op_arith_c;

  logic [W-1:0]  alu_src1_c, alu_src2_c, alu_b_c, alu_result_c;
  logic [CW-1:0] alu_ctrl_c;
  logic [W:0]    alu_sum_c;
  logic          alu_sub_c, alu_ovf_raw_c, alu_zero_c, alu_cout_c, alu_ovf_c;

`ifdef ALU_ARB_RR_EN
  // Last-grant register: the other requester gets priority on the next contention.
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept_c) begin
      last_q <= grant_id_c;
    end
  end

  assign prio0_c = last_q;
`else
  assign prio0_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept_c   = 1'b0;
    grant_id_c = 1'b0;
    capture_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_valid && (!req1_valid || prio0_c)) begin
          req0_ready = 1'b1;
          accept_c   = 1'b1;
          state_d    = ST_EXEC;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
          accept_c   = 1'b1;
          grant_id_c = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture_c = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_src1_q <= '0;
      op_src2_q <= '0;
      op_ctrl_q <= '0;
      op_id_q   <= 1'b0;
    end else if (accept_c) begin
      op_src1_q <= grant_id_c ? req1_src1 : req0_src1;
      op_src2_q <= grant_id_c ? req1_src2 : req0_src2;
      op_ctrl_q <= grant_id_c ? req1_ctrl : req0_ctrl;
      op_id_q   <= grant_id_c;
    end
  end

  // Unsupported codes run a harmless 0+0 ADD so the ALU never sees an undefined control.
  always_comb begin
    op_supported_c = 1'b0;
    op_arith_c     = 1'b0;
    case (op_ctrl_q)
      CTRL_ADD, CTRL_SUB, CTRL_SLT: begin
        op_supported_c = 1'b1;
        op_arith_c     = 1'b1;
      end
      CTRL_AND, CTRL_OR, CTRL_NOR, CTRL_NAND: op_supported_c = 1'b1;
      default: ;
    endcase
    alu_ctrl_c = op_supported_c ? op_ctrl_q : CTRL_ADD;
    alu_src1_c = op_supported_c ? op_src1_q : '0;
    alu_src2_c = op_supported_c ? op_src2_q : '0;
  end

  // Shared ALU: SUB and SLT use src1 + ~src2 + 1, so cout is the no-borrow carry.
  always_comb begin : u_alu
    alu_sub_c     = (alu_ctrl_c == CTRL_SUB) || (alu_ctrl_c == CTRL_SLT);
    alu_b_c       = alu_sub_c ? ~alu_src2_c : alu_src2_c;
    alu_sum_c     = {1'b0, alu_src1_c} + {1'b0, alu_b_c} + (W+1)'(alu_sub_c);
    alu_ovf_raw_c = (alu_src1_c[W-1] == alu_b_c[W-1]) && (alu_sum_c[W-1] != alu_src1_c[W-1]);
    alu_result_c  = '0;
    alu_cout_c    = 1'b0;
    alu_ovf_c     = 1'b0;
    case (alu_ctrl_c)
      CTRL_AND:  alu_result_c = alu_src1_c & alu_src2_c;
      CTRL_OR:   alu_result_c = alu_src1_c | alu_src2_c;
      CTRL_NOR:  alu_result_c = ~(alu_src1_c | alu_src2_c);
      CTRL_NAND: alu_result_c = ~(alu_src1_c & alu_src2_c);
      CTRL_ADD, CTRL_SUB: begin
        alu_result_c = alu_sum_c[W-1:0];
        alu_cout_c   = alu_sum_c[W];
        alu_ovf_c    = alu_ovf_raw_c;
      end
      CTRL_SLT: begin
        alu_result_c = W'($signed(alu_src1_c) < $signed(alu_src2_c));
        alu_cout_c   = alu_sum_c[W];
        alu_ovf_c    = alu_ovf_raw_c;
      end
      default: ;
    endcase
    if (!rst_n) begin
      alu_result_c = '0;
      alu_cout_c   = 1'b0;
      alu_ovf_c    = 1'b0;
    end
    alu_zero_c = (alu_result_c == '0);
  end

  always_comb begin
    rsp_result_d = alu_result_c;
    rsp_zero_d   = alu_zero_c;
    rsp_cout_d   = 1'b0;
    rsp_ovf_d    = 1'b0;
    rsp_err_d    = 1'b0;
    if (!op_supported_c) begin
      rsp_result_d = '0;
      rsp_zero_d   = 1'b1;
      rsp_err_d    = 1'b1;
    end else if (op_arith_c) begin
      rsp_cout_d = alu_cout_c;
      rsp_ovf_d  = alu_ovf_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else if (capture_c) begin
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
      rsp_id_q     <= op_id_q;
    end
  end

  assign rsp_valid    = (state_q == ST_RESP);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_cout     = rsp_cout_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, ALU ops, flags, arbitration, backpressure,
// unsupported codes and reset during EXEC. Works with or without ALU_ARB_RR_EN.
module tb_alu_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_cout, rsp_overflow, rsp_err, busy;

  int vectors;
  int miscompares;

  alu_arbiter #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Issues one op on requester id, waits for the grant and then for rsp_valid (both bounded).
  // lat = edges after the accept edge at which rsp_valid was first seen, -1 on timeout.
  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, output logic [31:0] res, output logic z,
                        output logic co, output logic ov, output logic er,
                        output logic rid, output int lat);
    logic g;
    g = 1'b0;
    lat = -1; res = '0; z = 1'b0; co = 1'b0; ov = 1'b0; er = 1'b0; rid = 1'b0;
    if (id == 1'b0) begin
      req0_src1 = a; req0_src2 = b; req0_ctrl = c; req0_valid = 1'b1;
    end else begin
      req1_src1 = a; req1_src2 = b; req1_ctrl = c; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      g = id ? req1_ready : req0_ready;
      @(posedge clk); #1;
      if (g) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (g) begin
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (rsp_valid) begin
          lat = i + 1;
          res = rsp_result; z = rsp_zero; co = rsp_cout; ov = rsp_overflow;
          er = rsp_err; rid = rsp_id;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_src1 = '0; req0_src2 = '0; req0_ctrl = '0;
    req1_src1 = '0; req1_src2 = '0; req1_ctrl = '0;
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++; if (rsp_result !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
    vectors++; if ({rsp_id, rsp_zero, rsp_cout, rsp_overflow, rsp_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_rsp_flags: got %b expected 00000", {rsp_id, rsp_zero, rsp_cout, rsp_overflow, rsp_err}); end
    vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    req0_src1 = 32'd7; req0_src2 = 32'd5; req0_ctrl = 4'b0010; req0_valid = 1'b1;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL add_grant: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;  // accept edge N
    req0_valid = 1'b0;
    vectors++; if ({busy, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL add_exec: busy/rsp_valid got %b expected 10", {busy, rsp_valid}); end
    @(posedge clk); #1;  // response valid, sampled by the consumer at edge N+2
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL add_rsp_valid: got %b expected 1", rsp_valid); end
    vectors++; if (rsp_result !== 32'd12) begin miscompares++; $display("FAIL add_result: got %h expected %h", rsp_result, 32'd12); end
    vectors++; if ({rsp_zero, rsp_id, rsp_err} !== 3'b000) begin miscompares++; $display("FAIL add_zero_id_err: got %b expected 000", {rsp_zero, rsp_id, rsp_err}); end
    @(posedge clk); #1;
    vectors++; if ({busy, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL add_return_idle: busy/rsp_valid got %b expected 00", {busy, rsp_valid}); end
  endtask

  task automatic test_sub();
    logic [31:0] res; logic z, co, ov, er, rid; int lat;
    rsp_ready = 1'b1;
    run_op(1'b1, 32'h8000_0000, 32'h1, 4'b0110, res, z, co, ov, er, rid, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL sub_latency: got %0d expected 1", lat); end
    vectors++; if (res !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL sub_ovf_result: got %h expected 7fffffff", res); end
    vectors++; if ({ov, co, z, er, rid} !== 5'b11001) begin miscompares++; $display("FAIL sub_ovf_flags: ov/co/z/err/id got %b expected 11001", {ov, co, z, er, rid}); end
    run_op(1'b1, 32'd5, 32'd5, 4'b0110, res, z, co, ov, er, rid, lat);
    vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL sub_eq_result: got %h expected 0", res); end
    vectors++; if ({z, ov} !== 2'b10) begin miscompares++; $display("FAIL sub_eq_flags: z/ov got %b expected 10", {z, ov}); end
  endtask

  task automatic test_slt_nor();
    logic [31:0] res; logic z, co, ov, er, rid; int lat;
    rsp_ready = 1'b1;
    run_op(1'b0, 32'hFFFF_FFFD, 32'd2, 4'b0111, res, z, co, ov, er, rid, lat);
    vectors++; if (res !== 32'd1) begin miscompares++; $display("FAIL slt_neg_lt_pos: got %h expected 1", res); end
    vectors++; if (z !== 1'b0) begin miscompares++; $display("FAIL slt_neg_lt_pos_zero: got %b expected 0", z); end
    run_op(1'b0, 32'd2, 32'hFFFF_FFFD, 4'b0111, res, z, co, ov, er, rid, lat);
    vectors++; if (res !== 32'd0) begin miscompares++; $display("FAIL slt_pos_lt_neg: got %h expected 0", res); end
    vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL slt_pos_lt_neg_zero: got %b expected 1", z); end
    run_op(1'b1, 32'd0, 32'd0, 4'b1100, res, z, co, ov, er, rid, lat);
    vectors++; if (res !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL nor_result: got %h expected ffffffff", res); end
    vectors++; if ({co, ov, z, er} !== 4'b0000) begin miscompares++; $display("FAIL nor_flags: co/ov/z/err got %b expected 0000", {co, ov, z, er}); end
  endtask

  task automatic test_logic();
    logic [31:0] res; logic z, co, ov, er, rid; int lat;
    rsp_ready = 1'b1;
    run_op(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, res, z, co, ov, er, rid, lat);
    vectors++; if (res !== 32'hF000_F000) begin miscompares++; $display("FAIL and_result: got %h expected f000f000", res); end
    run_op(1'b1, 32'h0000_00F0, 32'h0F00_0000, 4'b0001, res, z, co, ov, er, rid, lat);
    vectors++; if (res !== 32'h0F00_00F0) begin miscompares++; $display("FAIL or_result: got %h expected 0f0000f0", res); end
    vectors++; if (rid !== 1'b1) begin miscompares++; $display("FAIL or_id: got %b expected 1", rid); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, res, z, co, ov, er, rid, lat);
    vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL nand_result: got %h expected 0", res); end
    vectors++; if ({z, co, ov} !== 3'b100) begin miscompares++; $display("FAIL nand_flags: z/co/ov got %b expected 100", {z, co, ov}); end
  endtask

  task automatic test_contention();
    logic got_id [4];
    logic [31:0] got_res [4];
    logic [3:0] exp_ids;
    logic r1_seen;
    int n;
    n = 0; r1_seen = 1'b0;
`ifdef ALU_ARB_RR_EN
    exp_ids = 4'b1010;  // bit k = expected id of response k: 0,1,0,1
`else
    exp_ids = 4'b0000;
`endif
    rst_n = 1'b0; #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_src1 = 32'd1; req0_src2 = 32'd1; req0_ctrl = 4'b0010;
    req1_src1 = 32'd2; req1_src2 = 32'd2; req1_ctrl = 4'b0010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      #1;
      if (req1_ready) r1_seen = 1'b1;
      @(posedge clk); #1;
      if (rsp_valid) begin
        got_id[n] = rsp_id; got_res[n] = rsp_result; n++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL contention_count: got %0d responses expected 4", n); end
    for (int k = 0; k < n; k++) begin
      vectors++; if (got_id[k] !== exp_ids[k]) begin miscompares++; $display("FAIL contention_id%0d: got %b expected %b", k, got_id[k], exp_ids[k]); end
      vectors++; if (got_res[k] !== (exp_ids[k] ? 32'd4 : 32'd2)) begin
        miscompares++; $display("FAIL contention_res%0d: got %h expected %h", k, got_res[k], (exp_ids[k] ? 32'd4 : 32'd2)); end
    end
`ifdef ALU_ARB_RR_EN
    vectors++; if (r1_seen !== 1'b1) begin miscompares++; $display("FAIL contention_req1_granted: got %b expected 1", r1_seen); end
`else
    vectors++; if (r1_seen !== 1'b0) begin miscompares++; $display("FAIL contention_req1_starved: got %b expected 0", r1_seen); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure_bad();
    logic [31:0] res; logic z, co, ov, er, rid; int lat;
    rsp_ready = 1'b0;
    run_op(1'b0, 32'd3, 32'd4, 4'b1111, res, z, co, ov, er, rid, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL bad_latency: got %0d expected 1", lat); end
    req0_src1 = 32'd9; req0_src2 = 32'd9; req0_ctrl = 4'b0010; req0_valid = 1'b1;
    req1_src1 = 32'd8; req1_src2 = 32'd8; req1_ctrl = 4'b0010; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++; if ({rsp_valid, busy} !== 2'b11) begin miscompares++; $display("FAIL bp_valid_busy%0d: got %b expected 11", k, {rsp_valid, busy}); end
      vectors++; if (rsp_result !== 32'h0) begin miscompares++; $display("FAIL bp_result%0d: got %h expected 0", k, rsp_result); end
      vectors++; if ({rsp_err, rsp_zero, rsp_cout, rsp_overflow, rsp_id} !== 5'b11000) begin
        miscompares++; $display("FAIL bp_flags%0d: err/z/co/ov/id got %b expected 11000", k, {rsp_err, rsp_zero, rsp_cout, rsp_overflow, rsp_id}); end
      #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL bp_ready%0d: got %b expected 00", k, {req0_ready, req1_ready}); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    vectors++; if ({busy, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL bp_release: busy/rsp_valid got %b expected 00", {busy, rsp_valid}); end
  endtask

  task automatic test_reset_in_exec();
    logic seen;
    seen = 1'b0;
    rsp_ready = 1'b1;
    req1_src1 = 32'd1; req1_src2 = 32'd2; req1_ctrl = 4'b0010; req1_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    vectors++; if ({busy, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL rexec_in_exec: busy/rsp_valid got %b expected 10", {busy, rsp_valid}); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({busy, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL rexec_async: busy/rsp_valid got %b expected 00", {busy, rsp_valid}); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rexec_no_response: got %b expected 0", seen); end
    req0_src1 = 32'd10; req0_src2 = 32'd20; req0_ctrl = 4'b0010; req0_valid = 1'b1;
    req1_src1 = 32'd1;  req1_src2 = 32'd1;  req1_ctrl = 4'b0010; req1_valid = 1'b1;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL rexec_first_grant: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if ({rsp_valid, rsp_id} !== 2'b10) begin miscompares++; $display("FAIL rexec_rsp: valid/id got %b expected 10", {rsp_valid, rsp_id}); end
    vectors++; if (rsp_result !== 32'd30) begin miscompares++; $display("FAIL rexec_result: got %h expected %h", rsp_result, 32'd30); end
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_sub();
    test_slt_nor();
    test_logic();
    test_contention();
    test_backpressure_bad();
    test_reset_in_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the 32-bit `alu` datapath. Each requester presents an operation (operands plus the 4-bit ALU control code) over a valid/ready handshake. The block grants one requester, registers the operands, and drives one internal `alu` instance. It then returns the result and flags on a shared response channel tagged with the requester id. It sits between the decode/issue stage and the single shared ALU, so the ALU is never driven by two sources in the same operation.

## Interface
- `W`, 32, datapath width; only 32 is supported, matching `alu`.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset; also tied to the internal `alu` `rst_n`.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_src1`, `req0_src2`, `req1_src1`, `req1_src2`  in  W  operands.
- `req0_ctrl`, `req1_ctrl`  in  4  ALU control code.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester that issued the response.
- `rsp_result`  out  W  ALU result.
- `rsp_zero`, `rsp_cout`, `rsp_overflow`  out  1  ALU flags.
- `rsp_err`  out  1  unsupported control code.
- `busy`  out  1  state is not IDLE.

## Operation
- Supported codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
  - 1100 NOR, 1101 NAND, 0111 SLT
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `reqN_valid` is high, the arbiter picks a winner and asserts its `reqN_ready` combinationally in the same cycle.
  - On that edge the block captures `src1`, `src2`, `ctrl` and id into operation registers, then goes to EXEC.
  - The loser's `ready` stays 0.
- EXEC:
  - The ALU is driven only from the operation registers.
  - At the end of the cycle the block captures result and flags into the response registers, then goes to RESP.
- RESP:
  - `rsp_valid`=1 and all `rsp_*` outputs are held stable.
  - On `rsp_valid && rsp_ready` the block returns to IDLE.
  - No request is accepted in EXEC or RESP: both `reqN_ready` are 0.
- Flag rules:
  - ADD, SUB and SLT pass `zero`, `cout` and `overflow` from the ALU.
  - AND, OR, NOR and NAND pass `zero`; `rsp_cout` and `rsp_overflow` are forced to 0.
- Unsupported code:
  - The ALU control input is driven to 0010 with both operands 0.
  - The response carries `rsp_err`=1, `rsp_result`=0, `rsp_zero`=1, `rsp_cout`=0 and `rsp_overflow`=0.
- SLT result is 0 or 1 (signed compare) per the ALU definition.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE, `busy`=0, `rsp_valid`=0.
  - All `rsp_*` data outputs 0.
  - Operation registers 0.
  - Last-grant register = 1, so req0 wins first.
- Latency: accept on edge N; `rsp_valid` is high from edge N+2.
  - The minimum gap between accepts is 3 cycles, given `rsp_ready` is held high.
- Response handshake: data is held until accepted; `rsp_valid` never drops without a handshake except on reset.
- Reset mid-operation:
  - Any in-flight operation or pending response is discarded.
  - The block is IDLE at the first edge after `rst_n` rises.
- Requests must stay stable while `valid` is high and `ready` is low.
  - Deasserting `valid` before grant is permitted and simply withdraws the request.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - On contention the winner is the requester not granted last.
  - The last-grant register updates on every accept.
- `ALU_ARB_RR_EN` undefined: fixed priority, req0 always wins on contention.
  - The last-grant register is absent.
- Arbitration without contention is identical in both builds: the sole requester is granted.

## Test plan
- ADD: req0 ADD 7,5; `rsp_ready`=1.
  - Response: `rsp_result`=12, zero=0, id=0, err=0.
  - `rsp_valid` rises 2 cycles after accept and drops after one cycle.
- SUB overflow: req1 SUB 0x80000000,1.
  - Response: result 0x7FFFFFFF, overflow=1, cout=1, id=1.
  - A follow-up SUB 5,5 gives result 0, zero=1.
- SLT: SLT 0xFFFFFFFD,2 -> result 1. SLT 2,0xFFFFFFFD -> result 0. NOR 0,0 -> 0xFFFFFFFF with cout=0 and overflow=0.
- Contention: both requesters valid continuously, `rsp_ready`=1.
  - With `ALU_ARB_RR_EN` the response ids are 0,1,0,1.
  - Without the macro the ids are 0,0,0,0 and req1 is never granted.
- Backpressure and bad code: req0 ctrl 4'b1111 with `rsp_ready` held 0 for 5 cycles.
  - `rsp_valid` stays 1 with stable err=1, result=0, zero=1.
  - Both `ready` outputs stay 0 and `busy`=1.
  - Raising `rsp_ready` returns the block to IDLE.
- Reset in EXEC: `rst_n` pulsed low while the block is in EXEC.
  - `rsp_valid`=0 and `busy`=0 immediately.
  - No response appears afterward, and the next request is granted to req0.
